// File: rtl/param_bank.sv
// param_bank: trigger-loaded runtime parameter register bank.
// Each channel holds an active value (driven onto params_out) and a shadow
// value. Loads go to both in immediate mode, or to the shadow only in staged
// mode; staged values move to active together on a sim_clk rising edge or on
// a flush pulse, so a simulation step never sees a partly updated set.
module param_bank #(
    parameter int unsigned      NCH      = 16,
    parameter int unsigned      W        = 32,
    parameter logic [NCH*W-1:0] DEFAULTS = '0,
    parameter int unsigned      SEL_W    = 4
) (
    input  logic             clk,
    input  logic             reset_global,
    input  logic [NCH-1:0]   trig,
    input  logic [15:0]      data_lo,
    input  logic [15:0]      data_hi,
    input  logic             staged,
    input  logic             sim_clk,
    input  logic             flush,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic             rd_shadow,
    output logic [NCH*W-1:0] params_out,
    output logic [W-1:0]     rd_data,
    output logic [NCH-1:0]   pending,
    output logic [NCH-1:0]   update_strobe,
    output logic [15:0]      commit_cnt
);

    logic [31:0]           ld_full;
    logic [W-1:0]          ld;

    logic                  s1_q, s2_q, s3_q;
    logic                  tick;
    logic                  commit_ev;

    logic [NCH-1:0][W-1:0] active_q, active_d;
    logic [NCH-1:0][W-1:0] shadow_q, shadow_d;
    logic [NCH-1:0]        pending_q, pending_d;
    logic [NCH-1:0]        strobe_q, strobe_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [W-1:0]          rd_q, rd_d;

    // Load word assembly and commit-event decode.
    always_comb begin
        ld_full   = {data_hi, data_lo};
        ld        = ld_full[W-1:0];
        tick      = s2_q & ~s3_q;
        commit_ev = tick | flush;
    end

    // Synchronise sim_clk into the clk domain; s2/s3 form the rising-edge detector.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sim_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Per-channel next state. An immediate load overrides everything on its
    // channel; otherwise a pending commit moves the old shadow to active while
    // a coincident staged load refills the shadow and keeps pending set.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        strobe_d  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (trig[i] && !staged) begin
                active_d[i]  = ld;
                shadow_d[i]  = ld;
                pending_d[i] = 1'b0;
                strobe_d[i]  = 1'b1;
            end else begin
                if (commit_ev && pending_q[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                    strobe_d[i]  = 1'b1;
                end
                if (trig[i]) begin
                    shadow_d[i]  = ld;
                    pending_d[i] = 1'b1;
                end
            end
        end
    end

    // Commit counter: only events that actually moved at least one channel count.
    always_comb begin
        cnt_d = cnt_q;
        if (commit_ev && (|pending_q)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Readback mux; selects outside the channel range read as zero.
    always_comb begin
        rd_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_d = rd_shadow ? shadow_q[i] : active_q[i];
            end
        end
    end

    // Bank state, strobes, counter and readback registers.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            active_q  <= DEFAULTS;
            shadow_q  <= DEFAULTS;
            pending_q <= '0;
            strobe_q  <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            strobe_q  <= strobe_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
        end
    end

    assign params_out    = active_q;
    assign rd_data       = rd_q;
    assign pending       = pending_q;
    assign update_strobe = strobe_q;
    assign commit_cnt    = cnt_q;

endmodule

// File: tb/tb_param_bank.sv
// Self-checking bench for param_bank: spec-level reference model feeding a
// scoreboard queue, with a negedge monitor comparing every DUT output.
module tb_param_bank;

    localparam int NCH = 16;
    localparam int W   = 32;

    function automatic logic [511:0] mk_def();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'hD000_0000 | 32'(i);
        v[4*32 +: 32] = 32'h42A0_0000;
        return v;
    endfunction

    localparam logic [511:0] DEF = mk_def();

    logic         clk = 1'b0;
    logic         reset_global;
    logic [15:0]  trig;
    logic [15:0]  data_lo, data_hi;
    logic         staged, sim_clk, flush;
    logic [4:0]   rd_sel;
    logic         rd_shadow;
    logic [511:0] params_out;
    logic [31:0]  rd_data;
    logic [15:0]  pending, update_strobe, commit_cnt;

    param_bank #(.NCH(NCH), .W(W), .DEFAULTS(DEF), .SEL_W(5)) dut (
        .clk(clk), .reset_global(reset_global), .trig(trig),
        .data_lo(data_lo), .data_hi(data_hi), .staged(staged),
        .sim_clk(sim_clk), .flush(flush), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
        .params_out(params_out), .rd_data(rd_data), .pending(pending),
        .update_strobe(update_strobe), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic void chk(input string nm, input logic [511:0] a, input logic [511:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, a, x, $time);
        end
    endfunction

    function automatic logic [31:0] chan(input int i);
        return params_out[i*32 +: 32];
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int           cyc;
        logic [511:0] params;
        logic [15:0]  pend;
        logic [15:0]  strobe;
        logic [15:0]  cnt;
        logic [31:0]  rd;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_act[16];
    logic [31:0] m_sh[16];
    bit          m_pend[16];
    int          m_cnt;
    bit          hist[$];   // sim_clk value sampled at each clk edge

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_act[i]  = DEF[i*32 +: 32];
            m_sh[i]   = DEF[i*32 +: 32];
            m_pend[i] = 1'b0;
        end
        m_cnt = 0;
        hist.delete();
        repeat (3) hist.push_back(1'b0);
    endfunction

    function automatic void model_edge(input logic [15:0] t, input logic [31:0] d,
                                       input logic stg, input logic fl, input logic sc,
                                       input logic [4:0] rs, input logic rsh, output exp_t e);
        bit tick, commit, anyp;
        int n;
        e.strobe = '0;
        if (rs < 16) e.rd = rsh ? m_sh[rs] : m_act[rs];
        else         e.rd = '0;
        n    = hist.size();
        // rising edge seen two and three edges back drives the commit at this edge
        tick = hist[n-2] && !hist[n-3];
        hist.push_back(sc);
        commit = tick || fl;
        anyp = 0;
        for (int i = 0; i < 16; i++) if (m_pend[i]) anyp = 1;
        for (int i = 0; i < 16; i++) begin
            if (commit && m_pend[i]) begin
                m_act[i]    = m_sh[i];
                m_pend[i]   = 1'b0;
                e.strobe[i] = 1'b1;
            end
            if (t[i]) begin
                m_sh[i] = d;
                if (!stg) begin
                    m_act[i]    = d;
                    m_pend[i]   = 1'b0;
                    e.strobe[i] = 1'b1;
                end else begin
                    m_pend[i] = 1'b1;
                end
            end
        end
        if (commit && anyp) m_cnt = (m_cnt + 1) % 65536;
        for (int i = 0; i < 16; i++) begin
            e.params[i*32 +: 32] = m_act[i];
            e.pend[i]            = m_pend[i];
        end
        e.cnt = 16'(m_cnt);
    endfunction

    task automatic step(input logic [15:0] t, input logic [31:0] d, input logic stg,
                        input logic fl, input logic sc, input logic [4:0] rs, input logic rsh);
        exp_t e;
        trig = t; {data_hi, data_lo} = d; staged = stg; flush = fl;
        sim_clk = sc; rd_sel = rs; rd_shadow = rsh;
        model_edge(t, d, stg, fl, sc, rs, rsh, e);
        e.cyc = cyc + 1;
        sbq.push_back(e);
        @(posedge clk); #1;
        trig = '0; flush = 1'b0;
    endtask

    // ---------------- monitor ----------------
    exp_t me;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            me = sbq.pop_front();
            chk("sb_params", params_out, me.params);
            chk("sb_pending", pending, me.pend);
            chk("sb_strobe", update_strobe, me.strobe);
            chk("sb_commit_cnt", commit_cnt, me.cnt);
            chk("sb_rd_data", rd_data, me.rd);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [31:0] def15;
    logic        scv;
    logic [15:0] tr;

    initial begin
        reset_global = 1'b1;
        trig = '0; data_lo = '0; data_hi = '0; staged = 1'b0;
        sim_clk = 1'b0; flush = 1'b0; rd_sel = '0; rd_shadow = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_params", params_out, DEF);
        chk("rst_pending", pending, 16'h0);
        chk("rst_strobe", update_strobe, 16'h0);
        chk("rst_cnt", commit_cnt, 16'h0);
        chk("rst_rd", rd_data, 32'h0);
        reset_global = 1'b0;

        // 1: readback of default
        chk("t1_ch4", chan(4), 32'h42A0_0000);
        step(16'h0, 32'h0, 0, 0, 0, 5'd4, 0);
        chk("t1_rd", rd_data, 32'h42A0_0000);

        // 2: immediate load
        step(16'h0002, 32'h3F66_6666, 0, 0, 0, 5'd1, 0);
        chk("t2_ch1", chan(1), 32'h3F66_6666);
        chk("t2_strobe", update_strobe, 16'h0002);
        chk("t2_pend", pending, 16'h0000);
        step(16'h0, 32'h0, 0, 0, 0, 5'd1, 0);
        chk("t2_strobe_off", update_strobe, 16'h0000);

        // 3: staged double load then sim_clk commit
        def15 = DEF[15*32 +: 32];
        step(16'h8000, 32'h3E71_4120, 1, 0, 0, 5'd15, 1);
        step(16'h8000, 32'h3D14_4674, 1, 0, 0, 5'd15, 1);
        chk("t3_hold", chan(15), def15);
        chk("t3_pend", pending[15], 1'b1);
        step(16'h0, 32'h0, 1, 0, 1, 5'd15, 1);   // first sample of sim_clk high
        step(16'h0, 32'h0, 1, 0, 1, 5'd15, 0);
        chk("t3_not_yet", chan(15), def15);
        step(16'h0, 32'h0, 1, 0, 1, 5'd15, 0);   // commit edge
        chk("t3_commit", chan(15), 32'h3D14_4674);
        chk("t3_cnt", commit_cnt, 16'd1);
        chk("t3_pend_clr", pending[15], 1'b0);
        chk("t3_strobe", update_strobe, 16'h8000);
        repeat (2) step(16'h0, 32'h0, 1, 0, 1, 5'd15, 0);
        chk("t3_single_commit", commit_cnt, 16'd1);
        step(16'h0, 32'h0, 1, 0, 0, 5'd0, 0);

        // 4: broadcast staged load then flush
        step(16'h0028, 32'h0000_0007, 1, 0, 0, 5'd3, 1);
        step(16'h0, 32'h0, 1, 1, 0, 5'd5, 1);
        chk("t4_ch3", chan(3), 32'h7);
        chk("t4_ch5", chan(5), 32'h7);
        chk("t4_strobe", update_strobe, 16'h0028);
        chk("t4_cnt", commit_cnt, 16'd2);

        // 5: trig coincident with a commit on the same channel
        step(16'h0004, 32'hAAAA_5555, 1, 0, 0, 5'd2, 0);
        step(16'h0, 32'h0, 1, 0, 1, 5'd2, 0);
        step(16'h0, 32'h0, 1, 0, 1, 5'd2, 0);
        step(16'h0004, 32'h1234_5678, 1, 0, 1, 5'd2, 1);
        chk("t5_active_A", chan(2), 32'hAAAA_5555);
        chk("t5_pend", pending[2], 1'b1);
        repeat (2) step(16'h0, 32'h0, 1, 0, 0, 5'd2, 1);
        repeat (3) step(16'h0, 32'h0, 1, 0, 1, 5'd2, 0);
        chk("t5_active_B", chan(2), 32'h1234_5678);
        chk("t5_cnt", commit_cnt, 16'd4);

        // mode switch: staged pending commits while in immediate mode
        step(16'h0080, 32'hCAFE_0001, 1, 0, 0, 5'd7, 1);
        repeat (3) step(16'h0, 32'h0, 0, 0, 0, 5'd7, 0);
        repeat (3) step(16'h0, 32'h0, 0, 0, 1, 5'd7, 0);
        chk("mode_commit", chan(7), 32'hCAFE_0001);
        step(16'h0, 32'h0, 0, 0, 0, 5'd0, 0);

        // randomized phase
        scv = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) scv = ~scv;
            tr = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom & $urandom);
            step(tr, $urandom, ($urandom_range(3) != 0), ($urandom_range(15) == 0), scv,
                 5'($urandom_range(20)), 1'($urandom_range(1)));
        end

        // 6: reset mid-operation with loads pending
        step(16'h00FF, 32'h5555_AAAA, 1, 0, 0, 5'd0, 0);
        @(negedge clk); #1;
        reset_global = 1'b1;
        #1;
        chk("t6_params", params_out, DEF);
        chk("t6_pend", pending, 16'h0);
        chk("t6_cnt", commit_cnt, 16'h0);
        sim_clk = 1'b1;
        repeat (2) @(posedge clk);
        sim_clk = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset_global = 1'b0;
        step(16'h0, 32'h0, 1, 0, 0, 5'd4, 0);
        repeat (4) step(16'h0, 32'h0, 1, 0, 1, 5'd4, 0);
        chk("t6_no_commit", commit_cnt, 16'h0);
        chk("t6_defaults", params_out, DEF);

        repeat (2) @(negedge clk);
        #1;
        chk("sb_drain", 512'(sbq.size()), 512'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_bank.md
Name: param_bank

Overview:
- Parametrised, trigger-loaded register bank for runtime model parameters (gamma_dyn/sta, BDAMP_*, pps coefs, gains, half_cnt).
- Replaces the per-parameter hand-written trigger registers in the top level.
- Each channel loads {ep02wire, ep01wire} on its okTriggerIn bit.
- Supports immediate or staged, double-buffered update; staged values commit atomically on the sim_clk rising edge, so a sim step never sees a half-updated parameter set.

Parameters:
NCH, 16, number of parameter channels (1..16, one per trigger bit).
W, 32, parameter width in bits (1..32); loaded value is {data_hi, data_lo}[W-1:0].
DEFAULTS, {NCH{32'h0}}, packed NCH*W reset values; channel i default is DEFAULTS[i*W +: W].
SEL_W, 4, rd_sel width; must satisfy 2^SEL_W >= NCH.

Ports:
clk  in  1  system clock (clk1); trig is synchronous to it.
reset_global  in  1  reset, asynchronous, active-high.
trig  in  NCH  one-cycle load pulses, bit i loads channel i.
data_lo  in  16  low half of load word (ep01wire).
data_hi  in  16  high half of load word (ep02wire).
staged  in  1  0 = immediate mode, 1 = staged mode.
sim_clk  in  1  simulation clock (level), asynchronous to clk.
flush  in  1  one-cycle pulse: commit all pending now, regardless of sim_clk.
rd_sel  in  SEL_W  readback channel select.
rd_shadow  in  1  readback source: 0 = active value, 1 = shadow value.
params_out  out  NCH*W  active values; channel i at [i*W +: W].
rd_data  out  W  registered readback.
pending  out  NCH  shadow differs from committed (written, not yet committed).
update_strobe  out  NCH  one-cycle pulse when active[i] changes source (commit or immediate load).
commit_cnt  out  16  number of staged commit events since reset; wraps.

Behaviour:
- Reset (async, on reset_global high):
  - active[i] = shadow[i] = DEFAULTS[i].
  - pending = 0, update_strobe = 0, commit_cnt = 0, rd_data = 0.
  - sim_clk sync flops = 0.
  - Held in reset while high; normal operation from the first clk edge after deassertion.
- Load word: ld = {data_hi, data_lo}[W-1:0], sampled on the edge where trig[i] = 1.
- Multiple trig bits high in one cycle: every asserted channel loads the same ld (broadcast, no priority).
- Immediate mode (staged = 0), trig[i]:
  - shadow[i] and active[i] = ld at that edge; pending[i] cleared.
  - update_strobe[i] = 1 for the following cycle.
- Staged mode (staged = 1), trig[i]:
  - shadow[i] = ld, pending[i] = 1; active unchanged.
  - Repeated trig before commit overwrites shadow; last value wins.
- sim_clk sync/edge detect:
  - Three-flop chain s1 → s2 → s3; tick = s2 & ~s3.
  - If sim_clk is first sampled 1 at edge k, tick is high in the cycle after edge k+1 and the commit occurs at edge k+2.
- Commit event (tick or flush):
  - For every i with pending[i] = 1: active[i] = shadow[i], pending[i] = 0, update_strobe[i] pulses next cycle.
  - commit_cnt increments by 1 only if at least one channel was pending; wraps 0xFFFF → 0.
  - tick and flush in the same cycle count as one commit event.
- Trig coincident with a commit on the same channel (staged):
  - active takes the old shadow; shadow takes ld; pending stays 1.
  - New value commits on the next event.
- Mode switch: pending bits left from staged mode still commit on the next tick/flush even while staged = 0.
  - An immediate-mode trig on a pending channel overwrites both registers and clears pending.
- Readback: rd_data registered, 1-cycle latency.
  - Selects active[rd_sel] or shadow[rd_sel] per rd_shadow.
  - rd_sel >= NCH returns 0.
- params_out is a direct register output; no combinational path from trig.
- update_strobe is never high for more than one cycle per event.

Test Plan:
1. Reset release, NCH=16, DEFAULTS ch4 = 0x42A0_0000 → params_out[4] = 0x42A0_0000, pending = 0, commit_cnt = 0; rd_sel = 4 gives 0x42A0_0000 one cycle later.
2. staged = 0, data = 0x3F66_6666, trig[1] pulse → active[1] = 0x3F66_6666 next edge; update_strobe[1] single pulse; pending[1] = 0.
3. staged = 1, trig[15] with 0x3E71_4120, then trig[15] with 0x3D14_4674 → active[15] unchanged and pending[15] = 1.
   - Then sim_clk rises → active[15] = 0x3D14_4674 exactly 2 clk after first sample; commit_cnt = 1; pending clears.
4. staged = 1, trig[3] = trig[5] = 1 together with 0x0000_0007, then flush → both channels = 7; update_strobe = 0x0028; commit_cnt increments once.
5. staged = 1, trig[2] with A, sim tick; trig[2] with B in the commit cycle → active[2] = A, pending[2] = 1; next tick → active[2] = B.
6. Loads in flight, assert reset_global mid-operation → all channels at DEFAULTS immediately, pending = 0; a subsequent sim_clk edge causes no commit and commit_cnt stays 0.
